hit_ser_master: RTL

- Initiator for the 2-bit-address / 16-bit-data configuration write port of the PLL/TRNG/noise configuration decoder.
- Deserialises framed single-bit commands sampled in the clk domain and checks parity and frame length.
- Buffers accepted commands in a small FIFO and issues each as a one-cycle valid/address/data write, with a programmable idle gap between writes.

---
 rtl/hit_ser_master.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/hit_ser_master.sv
// ---------------------------------------------------------------------------
// hit_ser_master
//
// Serial-to-parallel initiator for the 2-bit-address / 16-bit-data
// configuration write port of the PLL/TRNG/noise configuration decoder.
// Framed single-bit commands, sampled in the clk domain, are deserialised
// and checked for length and even parity. Good frames with a non-zero
// address are queued in a small FIFO. An issue FSM drains the FIFO as
// one-cycle valid/address/data writes, with GAP_CYCLES valid-low cycles
// after every write.
//
// Frame bit order: address[1], address[0], data[15]..data[0], parity.
//
// Handshake: valid is a one-cycle strobe with no back-pressure. address
// and data are meaningful in the valid cycle and hold their last issued
// values while valid is low.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   ser_frame     frame enable, high for exactly 19 cycles per command
//   ser_bit       serial data, sampled on each cycle ser_frame=1
//   valid         one-cycle write strobe
//   address       write address (1=PLL, 2=TRNG, 3=noise)
//   data          write payload
//   busy          registered OR of receiver busy, FIFO non-empty, issuer busy
//   frame_err     one-cycle pulse: short, long or parity-bad frame
//   overflow      one-cycle pulse: good frame dropped because FIFO full
//   dbg_rx_state  receive FSM state (0 idle, 1 shift, 2 drain)
//   dbg_iss_state issue FSM state (0 idle, 1 issue, 2 gap)
// ---------------------------------------------------------------------------
module hit_ser_master #(
   parameter int DEPTH      = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ser_frame,
   input  logic        ser_bit,
   output logic        valid,
   output logic [1:0]  address,
   output logic [15:0] data,
   output logic        busy,
   output logic        frame_err,
   output logic        overflow,
   output logic [1:0]  dbg_rx_state,
   output logic [1:0]  dbg_iss_state
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [4:0] FRAME_BITS = 5'd19;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_SHIFT = 2'd1,
      R_DRAIN = 2'd2
   } rx_state_e;

   typedef enum logic [1:0] {
      I_IDLE  = 2'd0,
      I_ISSUE = 2'd1,
      I_GAP   = 2'd2
   } iss_state_e;

   // receiver
   rx_state_e   rx_state_q;
   logic [4:0]  bit_cnt_q;
   logic [18:0] shift_q;
   logic        frame_err_q;
   logic        overflow_q;

   // FIFO
   logic [17:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;

   // issuer
   iss_state_e    iss_state_q;
   logic [GW-1:0] gap_q;
   logic          valid_q;
   logic [1:0]    address_q;
   logic [15:0]   data_q;
   logic          busy_q;

   // decode shared between the receiver, FIFO and issuer
   logic        fifo_full;
   logic        fifo_empty;
   logic        frame_done;
   logic        parity_ok;
   logic [1:0]  frame_addr;
   logic [15:0] frame_data;
   logic        push;
   logic        pop;
   logic        gap_last;

   always_comb begin
      fifo_full  = (count_q == CW'(DEPTH));
      fifo_empty = (count_q == '0);
      // accept cycle: frame enable dropped after exactly 19 bits
      frame_done = (rx_state_q == R_SHIFT) && !ser_frame && (bit_cnt_q == FRAME_BITS);
      parity_ok  = ~(^shift_q);
      frame_addr = shift_q[18:17];
      frame_data = shift_q[16:1];
      // full is judged on the occupancy at the start of the cycle, so a
      // frame arriving while full is dropped even if a pop happens now
      push       = frame_done && parity_ok && (frame_addr != 2'd0) && !fifo_full;
      gap_last   = (iss_state_q == I_GAP) && (gap_q == GW'(1));
      // issuing straight out of the final gap cycle keeps back-to-back
      // writes exactly 1+GAP_CYCLES cycles apart
      pop        = !fifo_empty && ((iss_state_q == I_IDLE) || gap_last);
   end

   // ---------------------------------------------------------------------
   // Receive FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q  <= R_IDLE;
         bit_cnt_q   <= 5'd0;
         shift_q     <= 19'd0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         case (rx_state_q)
            R_IDLE: begin
               if (ser_frame) begin
                  shift_q    <= {18'd0, ser_bit};
                  bit_cnt_q  <= 5'd1;
                  rx_state_q <= R_SHIFT;
               end
            end
            R_SHIFT: begin
               if (ser_frame) begin
                  if (bit_cnt_q == FRAME_BITS) begin
                     // 20th bit: report once, then swallow the rest
                     frame_err_q <= 1'b1;
                     rx_state_q  <= R_DRAIN;
                  end else begin
                     shift_q   <= {shift_q[17:0], ser_bit};
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end else begin
                  rx_state_q <= R_IDLE;
                  bit_cnt_q  <= 5'd0;
                  if (bit_cnt_q == FRAME_BITS) begin
                     if (!parity_ok) begin
                        frame_err_q <= 1'b1;
                     end else if ((frame_addr != 2'd0) && fifo_full) begin
                        overflow_q <= 1'b1;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
            end
            R_DRAIN: begin
               if (!ser_frame) begin
                  rx_state_q <= R_IDLE;
                  bit_cnt_q  <= 5'd0;
               end
            end
            default: begin
               rx_state_q <= R_IDLE;
               bit_cnt_q  <= 5'd0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // FIFO: pointers wrap naturally because DEPTH is a power of two;
   // occupancy runs 0..DEPTH so full and empty are unambiguous.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // storage needs no reset: an entry is only read after it is written
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {frame_addr, frame_data};
   end

   // ---------------------------------------------------------------------
   // Issue FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_state_q <= I_IDLE;
         gap_q       <= '0;
         valid_q     <= 1'b0;
         address_q   <= 2'd0;
         data_q      <= 16'd0;
         busy_q      <= 1'b0;
      end else begin
         busy_q <= (rx_state_q != R_IDLE) || !fifo_empty || (iss_state_q != I_IDLE);
         case (iss_state_q)
            I_IDLE: begin
               if (pop) begin
                  valid_q                <= 1'b1;
                  {address_q, data_q}    <= mem_q[rd_ptr_q];
                  iss_state_q            <= I_ISSUE;
               end
            end
            I_ISSUE: begin
               valid_q     <= 1'b0;
               gap_q       <= GW'(GAP_CYCLES);
               iss_state_q <= I_GAP;
            end
            I_GAP: begin
               if (gap_last) begin
                  if (pop) begin
                     valid_q             <= 1'b1;
                     {address_q, data_q} <= mem_q[rd_ptr_q];
                     iss_state_q         <= I_ISSUE;
                  end else begin
                     iss_state_q <= I_IDLE;
                  end
                  gap_q <= '0;
               end else begin
                  gap_q <= gap_q - GW'(1);
               end
            end
            default: begin
               valid_q     <= 1'b0;
               iss_state_q <= I_IDLE;
            end
         endcase
      end
   end

   assign valid         = valid_q;
   assign address       = address_q;
   assign data          = data_q;
   assign busy          = busy_q;
   assign frame_err     = frame_err_q;
   assign overflow      = overflow_q;
   assign dbg_rx_state  = rx_state_q;
   assign dbg_iss_state = iss_state_q;

endmodule
